bus_slot_sequencer: RTL and testbench

//  Parametrised time-division bus sequencer. Splits a repeating frame into
//  NUM_SLOTS equal slots and, per slot, drives one-hot select/strobe windows
//  for that slot's bus initiator (Pi, CPU, video, ...). Only slots whose

---
 rtl/bus_slot_sequencer_if.sv | 40 ++++
 rtl/bus_slot_sequencer.sv | 139 +++++++++++++
 tb/tb_bus_slot_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_slot_sequencer_if.sv
// Bus bundle between the slot sequencer (master) and the initiators it
// serves (slave). slot_ready / slot_timeout exist only when WAIT_EN is
// defined, matching the sequencer's optional wait-state feature.
interface bus_slot_sequencer_if #(
    parameter int unsigned NUM_SLOTS = 2
);
    logic [NUM_SLOTS-1:0]         slot_req;
    logic [NUM_SLOTS-1:0]         slot_select;
    logic [NUM_SLOTS-1:0]         slot_strobe;
    logic [NUM_SLOTS-1:0]         slot_done;
    logic [$clog2(NUM_SLOTS)-1:0] slot_index;
    logic                         frame_start;

`ifdef WAIT_EN
    logic [NUM_SLOTS-1:0]         slot_ready;
    logic [NUM_SLOTS-1:0]         slot_timeout;

    modport master (
        input  slot_req, slot_ready,
        output slot_select, slot_strobe, slot_done, slot_timeout,
               slot_index, frame_start
    );

    modport slave (
        output slot_req, slot_ready,
        input  slot_select, slot_strobe, slot_done, slot_timeout,
               slot_index, frame_start
    );
`else
    modport master (
        input  slot_req,
        output slot_select, slot_strobe, slot_done, slot_index, frame_start
    );

    modport slave (
        output slot_req,
        input  slot_select, slot_strobe, slot_done, slot_index, frame_start
    );
`endif
endinterface

// File: rtl/bus_slot_sequencer.sv
// Time-division bus slot sequencer. A frame is NUM_SLOTS slots of
// SLOT_CYCLES clk16 cycles; slot i serves initiator i and drives one-hot
// select/strobe/done windows only if that initiator was requesting when the
// slot began. All outputs are registered from the next-state values, so the
// first cycle after reset release already shows frame cycle 0.
// Optional feature macro: WAIT_EN (strobe stretched by slot_ready, with
// a MAX_WAIT-cycle timeout reported on slot_timeout).
module bus_slot_sequencer #(
    parameter int unsigned NUM_SLOTS   = 2,
    parameter int unsigned SLOT_CYCLES = 8,
    parameter int unsigned SEL_START   = 0,
    parameter int unsigned SEL_LEN     = 3,
    parameter int unsigned STROBE_OFS  = 1,
    parameter int unsigned MAX_WAIT    = 4
) (
    input  logic                   clk16,
    input  logic                   reset_n,
    bus_slot_sequencer_if.master   bus
);

    localparam int unsigned CYC_W = $clog2(SLOT_CYCLES);
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    localparam logic [CYC_W-1:0]     CYC_LAST  = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [CYC_W-1:0]     SEL_FIRST = CYC_W'(SEL_START);
    localparam logic [CYC_W-1:0]     SEL_END   = CYC_W'(SEL_START + SEL_LEN - 1);
    localparam logic [CYC_W-1:0]     STB_CYC   = CYC_W'(STROBE_OFS);
    localparam logic [CYC_W:0]       SEL_SPAN  = (CYC_W + 1)'(SEL_LEN);
    localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(NUM_SLOTS - 1);
    localparam logic [NUM_SLOTS-1:0] SLOT_ONE  = {{(NUM_SLOTS - 1){1'b0}}, 1'b1};

    // Reject parameter sets that would break the one-hot window placement.
    if (NUM_SLOTS < 2 || SLOT_CYCLES < 2 || SEL_LEN < 1 ||
        SEL_START + SEL_LEN > SLOT_CYCLES ||
        STROBE_OFS < SEL_START || STROBE_OFS >= SEL_START + SEL_LEN ||
        MAX_WAIT < 1) begin : g_param_check
        $error("bus_slot_sequencer: illegal parameter combination");
    end

    // Position within the frame, and whether the current slot is serving.
    logic [CYC_W-1:0]     cyc,    cyc_n;
    logic [IDX_W-1:0]     slot,   slot_n;
    logic                 active, active_n;
    logic                 hold;
    logic                 in_sel_n;
    logic [CYC_W:0]       sel_rel_n;
    logic [NUM_SLOTS-1:0] slot_bit_n;

`ifdef WAIT_EN
    localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0]    wait_cnt, wait_n;
    logic                 forced;
    logic [NUM_SLOTS-1:0] timeout_bit_n;
`endif

    // Next frame position: normally one step, held at the strobe cycle while
    // an active slot's initiator is not ready (WAIT_EN only).
    always_comb begin
        hold     = 1'b0;
        cyc_n    = cyc;
        slot_n   = slot;
        active_n = active;
`ifdef WAIT_EN
        forced        = 1'b0;
        wait_n        = '0;
        timeout_bit_n = '0;
        if (active && cyc == STB_CYC && !bus.slot_ready[slot]) begin
            if (wait_cnt == WAIT_MAX) begin
                forced        = 1'b1;
                timeout_bit_n = SLOT_ONE << slot;
            end else begin
                hold   = 1'b1;
                wait_n = wait_cnt + 1'b1;
            end
        end
`endif
        if (!hold) begin
            if (cyc == CYC_LAST) begin
                cyc_n    = '0;
                slot_n   = (slot == IDX_LAST) ? '0 : slot + 1'b1;
                active_n = bus.slot_req[slot_n];
            end else begin
                cyc_n = cyc + 1'b1;
            end
        end
        // One extra bit keeps the window test free of wrap and of
        // always-true compares when SEL_START is 0.
        sel_rel_n  = {1'b0, cyc_n} - {1'b0, SEL_FIRST};
        in_sel_n   = sel_rel_n < SEL_SPAN;
        slot_bit_n = SLOT_ONE << slot_n;
    end

    // Frame position state; reset parks one cycle before frame cycle 0.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            cyc      <= CYC_LAST;
            slot     <= IDX_LAST;
            active   <= 1'b0;
`ifdef WAIT_EN
            wait_cnt <= '0;
`endif
        end else begin
            cyc      <= cyc_n;
            slot     <= slot_n;
            active   <= active_n;
`ifdef WAIT_EN
            wait_cnt <= wait_n;
`endif
        end
    end

    // Registered outputs decoded from the next position. done fires only on
    // entry to the last select cycle so it stays a single pulse even when
    // that cycle is the one being held.
    always_ff @(posedge clk16 or negedge reset_n) begin
        if (!reset_n) begin
            bus.slot_select  <= '0;
            bus.slot_strobe  <= '0;
            bus.slot_done    <= '0;
            bus.slot_index   <= '0;
            bus.frame_start  <= 1'b0;
`ifdef WAIT_EN
            bus.slot_timeout <= '0;
`endif
        end else begin
            bus.slot_select  <= (active_n && in_sel_n) ? slot_bit_n : '0;
            bus.slot_strobe  <= (active_n && cyc_n == STB_CYC) ? slot_bit_n : '0;
            bus.slot_done    <= (active_n && cyc_n == SEL_END && !hold) ? slot_bit_n : '0;
            bus.slot_index   <= slot_n;
            bus.frame_start  <= (slot_n == '0) && (cyc_n == '0);
`ifdef WAIT_EN
            bus.slot_timeout <= timeout_bit_n;
`endif
        end
    end

endmodule

// File: tb/tb_bus_slot_sequencer.sv
// Bench for bus_slot_sequencer: a default 2-slot instance and a 3-slot
// instance (5-cycle slots). Expected outputs come from a slot-level model:
// each slot is a list of positions whose length and contents follow from
// the request seen at slot entry and the number of not-ready samples chosen
// for that slot. Covers WAIT_EN when the macro is defined.
module tb_bus_slot_sequencer;

    logic clk16;
    logic rst_a, rst_b;
    int   checks;
    int   failures;

    bus_slot_sequencer_if #(.NUM_SLOTS(2)) bus_a ();
    bus_slot_sequencer_if #(.NUM_SLOTS(3)) bus_b ();

    bus_slot_sequencer #(
        .NUM_SLOTS(2), .SLOT_CYCLES(8), .SEL_START(0),
        .SEL_LEN(3), .STROBE_OFS(1), .MAX_WAIT(4)
    ) u_dut_a (
        .clk16   (clk16),
        .reset_n (rst_a),
        .bus     (bus_a)
    );

    bus_slot_sequencer #(
        .NUM_SLOTS(3), .SLOT_CYCLES(5), .SEL_START(1),
        .SEL_LEN(2), .STROBE_OFS(2), .MAX_WAIT(2)
    ) u_dut_b (
        .clk16   (clk16),
        .reset_n (rst_b),
        .bus     (bus_b)
    );

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    task automatic drive(input int which, input logic [7:0] req, input logic [7:0] rdy);
        if (which == 0) begin
            bus_a.slot_req = req[1:0];
`ifdef WAIT_EN
            bus_a.slot_ready = rdy[1:0];
`endif
        end else begin
            bus_b.slot_req = req[2:0];
`ifdef WAIT_EN
            bus_b.slot_ready = rdy[2:0];
`endif
        end
    endtask

    task automatic set_reset(input int which, input logic v);
        if (which == 0) rst_a = v;
        else            rst_b = v;
    endtask

    // outs = {select, strobe, done, timeout}, pos = {index, frame_start}
    task automatic observe(input int which, output logic [31:0] outs, output logic [7:0] pos);
        logic [7:0] to;
        to = '0;
        if (which == 0) begin
`ifdef WAIT_EN
            to = 8'(bus_a.slot_timeout);
`endif
            outs = {8'(bus_a.slot_select), 8'(bus_a.slot_strobe), 8'(bus_a.slot_done), to};
            pos  = {7'(bus_a.slot_index), bus_a.frame_start};
        end else begin
`ifdef WAIT_EN
            to = 8'(bus_b.slot_timeout);
`endif
            outs = {8'(bus_b.slot_select), 8'(bus_b.slot_strobe), 8'(bus_b.slot_done), to};
            pos  = {7'(bus_b.slot_index), bus_b.frame_start};
        end
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one DUT from reset for nslots slots. Request during cycle g is
    // req1 once g >= sw_cycle, else req0 (or random). kfix >= 0 fixes the
    // number of not-ready samples per active slot, -1 randomises it.
    // abort_at >= 0 asserts reset in the middle of that cycle.
    task automatic run_seq(input int which, input string name, input int nslots,
                           input logic [7:0] req0, input logic [7:0] req1,
                           input int sw_cycle, input bit rnd_req,
                           input int kfix, input int abort_at);
        int ns, sc, ss, sl, so, mw;
        int s, nxt, g, k, h, c, len;
        bit act, forced, first;
        logic [7:0]  req, rdy, carry_to, e_sel, e_str, e_dn, e_to;
        logic [31:0] o_out, e_out;
        logic [7:0]  o_pos, e_pos;

        if (which == 0) begin
            ns = 2; sc = 8; ss = 0; sl = 3; so = 1; mw = 4;
        end else begin
            ns = 3; sc = 5; ss = 1; sl = 2; so = 2; mw = 2;
        end

        @(negedge clk16);
        observe(which, o_out, o_pos);
        check($sformatf("%s_in_reset", name), {o_out, o_pos}, 40'h0);

        req = rnd_req ? 8'($urandom) : req0;
        drive(which, req, 8'($urandom));
        set_reset(which, 1'b1);

        act      = req[0];
        s        = 0;
        g        = 0;
        carry_to = '0;

        for (int n = 0; n < nslots; n++) begin
            k      = 0;
            h      = 0;
            forced = 1'b0;
`ifdef WAIT_EN
            k = (kfix >= 0) ? kfix : int'($urandom_range(mw + 2, 0));
            if (act) begin
                h      = (k < mw) ? k : mw;
                forced = (k > mw);
            end
`endif
            len = sc + h;
            nxt = (s == ns - 1) ? 0 : s + 1;
            for (int p = 0; p < len; p++) begin
                @(negedge clk16);
                if (p <= so)          c = p;
                else if (p <= so + h) c = so;
                else                  c = p - h;
                first = (p <= so) || (p > so + h);
                e_sel = (act && c >= ss && c < ss + sl) ? 8'(1 << s) : 8'h00;
                e_str = (act && c == so) ? 8'(1 << s) : 8'h00;
                e_dn  = (act && c == ss + sl - 1 && first) ? 8'(1 << s) : 8'h00;
                e_to  = (p == 0) ? carry_to : 8'h00;
                if (forced && p == so + h + 1) e_to = 8'(1 << s);
                e_out = {e_sel, e_str, e_dn, e_to};
                e_pos = {7'(s), (s == 0 && p == 0)};

                observe(which, o_out, o_pos);
                check($sformatf("%s_outs_c%0d", name, g), 40'(o_out), 40'(e_out));
                check($sformatf("%s_pos_c%0d", name, g), 40'(o_pos), 40'(e_pos));

                if (g == abort_at) begin
                    #1 set_reset(which, 1'b0);
                    #1 observe(which, o_out, o_pos);
                    check($sformatf("%s_async_reset", name), {o_out, o_pos}, 40'h0);
                    return;
                end

                req = rnd_req ? 8'($urandom) : ((g >= sw_cycle) ? req1 : req0);
                rdy = 8'($urandom);
`ifdef WAIT_EN
                if (act && p >= so && p <= so + h) rdy[s] = ((p - so) >= k);
`endif
                drive(which, req, rdy);
                g++;
            end
            carry_to = (forced && so + h + 1 == len) ? 8'(1 << s) : 8'h00;
            act = req[nxt];
            s   = nxt;
        end

        #1 set_reset(which, 1'b0);
        #1 observe(which, o_out, o_pos);
        check($sformatf("%s_end_reset", name), {o_out, o_pos}, 40'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;
        drive(0, 8'h00, 8'h00);
        drive(1, 8'h00, 8'h00);
        repeat (3) @(posedge clk16);

        // Both initiators requesting, three frames.
        run_seq(0, "both_req", 6, 8'h03, 8'h03, 0, 1'b0, 0, -1);
        // Only initiator 0: slot 1 idle but still consumes time.
        run_seq(0, "req_01", 4, 8'h01, 8'h01, 0, 1'b0, 0, -1);
        // Request rising inside slot 0 waits for the next frame.
        run_seq(0, "late_req", 4, 8'h00, 8'h01, 1, 1'b0, 0, -1);
        // Reset in the middle of slot 1, then a clean restart.
        run_seq(0, "mid_reset", 4, 8'h03, 8'h03, 0, 1'b0, 0, 9);
        run_seq(0, "restart", 4, 8'h03, 8'h03, 0, 1'b0, 0, -1);
`ifdef WAIT_EN
        // Two not-ready samples, then ready stuck low (timeout).
        run_seq(0, "wait2", 4, 8'h01, 8'h01, 0, 1'b0, 2, -1);
        run_seq(0, "wait_to", 4, 8'h01, 8'h01, 0, 1'b0, 99, -1);
`endif
        run_seq(0, "rand_a", 40, 8'h00, 8'h00, 0, 1'b1, -1, -1);

        // Three-slot instance: fixed all-request frames, then random.
        run_seq(1, "three_slot", 6, 8'h07, 8'h07, 0, 1'b0, 0, -1);
        run_seq(1, "rand_b", 40, 8'h00, 8'h00, 0, 1'b1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
